// File: rtl/uart_v2.sv
// uart_v2: memory-mapped UART with TX/RX serial engines, FIFOs and sticky error flags.

module uart_v2_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr[AW-1:0]];

   // Pointer update; the extra MSB tells full from empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end
endmodule

module uart_v2 #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DEFAULT_DIV = 104
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  reg_we,
   input  logic [3:0]  reg_re,
   input  logic [3:0]  reg_addr,
   input  logic [31:0] reg_di,
   output logic [31:0] reg_do,
   output logic        ready,
   input  logic        uart_rx,
   output logic        uart_tx
);
   localparam int unsigned DW = DATA_BITS;
   localparam int unsigned BW = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   logic [2:0]    cfg;
   logic [15:0]   div;
   logic          rx_overrun, frame_err, tx_overflow;
   logic          acc, wr, rd, st_wr;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic [DW-1:0] tx_rdata, tx_shift;
   logic          rx_pop, rx_full, rx_empty, rx_push, rx_ferr;
   logic [DW-1:0] rx_rdata, rx_shift;
   state_t        tx_state, rx_state;
   logic [15:0]   tx_div, tx_cnt, rx_div, rx_cnt;
   logic [BW-1:0] tx_bit, rx_bit;
   logic          tx_line, tx_tick, tx_busy, tx_start;
   logic [1:0]    rx_sync;
   logic          rx_in, rx_prev;
   logic [7:0]    status;
   logic [31:0]   rdata_c;
   logic          unused_di;

   assign acc      = ((|reg_we) || (|reg_re)) && !ready;
   assign wr       = acc && (|reg_we);
   assign rd       = acc && (|reg_re);
   assign st_wr    = wr && (reg_addr == 4'd2);
   assign tx_push  = wr && (reg_addr == 4'd3);
   assign rx_pop   = rd && (reg_addr == 4'd4);
   assign tx_tick  = (tx_cnt == tx_div - 16'd1);
   assign tx_start = cfg[0] && !tx_empty &&
                     ((tx_state == ST_IDLE) ||
                      ((tx_state == ST_STOP) && tx_tick && (tx_bit == BW'(STOP_BITS-1))));
   assign tx_pop   = tx_start;
   assign tx_busy  = (tx_state != ST_IDLE) || tx_start;
   assign rx_in    = cfg[2] ? tx_line : rx_sync[1];
   assign uart_tx  = cfg[2] ? 1'b1 : tx_line;
   assign status   = {tx_overflow, frame_err, rx_overrun, tx_busy,
                      rx_empty, rx_full, tx_empty, tx_full};
   assign unused_di = &{1'b0, reg_di[31:16]};

   uart_v2_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop),
      .wdata(reg_di[DW-1:0]), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty));

   uart_v2_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop),
      .wdata(rx_shift), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty));

   // Read-data mux for the register being accessed.
   always_comb begin
      rdata_c = '0;
      case (reg_addr)
         4'd0: rdata_c = {29'd0, cfg};
         4'd1: rdata_c = {16'd0, div};
         4'd2: rdata_c = {24'd0, status};
         4'd4: rdata_c = rx_empty ? '0 : 32'(rx_rdata);
         default: rdata_c = '0;
      endcase
   end

   // Register port: handshake, CFG/DIV storage and sticky flags (set beats W1C).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready       <= 1'b0;
         reg_do      <= '0;
         cfg         <= '0;
         div         <= 16'(DEFAULT_DIV);
         rx_overrun  <= 1'b0;
         frame_err   <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         ready  <= acc;
         reg_do <= rd ? rdata_c : '0;
         if (wr && (reg_addr == 4'd0)) cfg <= reg_di[2:0];
         if (wr && (reg_addr == 4'd1)) div <= (reg_di[15:0] < 16'd4) ? 16'd4 : reg_di[15:0];
         rx_overrun  <= (rx_overrun  && !(st_wr && reg_di[5])) || (rx_push && rx_full && !rx_pop);
         frame_err   <= (frame_err   && !(st_wr && reg_di[6])) || rx_ferr;
         tx_overflow <= (tx_overflow && !(st_wr && reg_di[7])) || (tx_push && tx_full && !tx_pop);
      end
   end

   // TX engine: start bit, LSB-first data, stop bits; chains frames without a gap.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_state <= ST_IDLE;
         tx_line  <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_div   <= 16'(DEFAULT_DIV);
         tx_shift <= '0;
      end else if (tx_start) begin
         tx_state <= ST_START;
         tx_line  <= 1'b0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_div   <= div;
         tx_shift <= tx_rdata;
      end else if (tx_state != ST_IDLE) begin
         if (!tx_tick) begin
            tx_cnt <= tx_cnt + 16'd1;
         end else begin
            tx_cnt <= '0;
            case (tx_state)
               ST_START: begin
                  tx_state <= ST_DATA;
                  tx_line  <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= '0;
               end
               ST_DATA: begin
                  if (tx_bit == BW'(DW-1)) begin
                     tx_state <= ST_STOP;
                     tx_line  <= 1'b1;
                     tx_bit   <= '0;
                  end else begin
                     tx_line  <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                     tx_bit   <= tx_bit + BW'(1);
                  end
               end
               ST_STOP: begin
                  if (tx_bit == BW'(STOP_BITS-1)) tx_state <= ST_IDLE;
                  else tx_bit <= tx_bit + BW'(1);
               end
               default: tx_state <= ST_IDLE;
            endcase
         end
      end
   end

   // RX engine: synchronise, mid-bit sampling, false-start and framing checks.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_state <= ST_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_div   <= 16'(DEFAULT_DIV);
         rx_shift <= '0;
         rx_push  <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], uart_rx};
         rx_prev <= rx_in;
         rx_push <= 1'b0;
         rx_ferr <= 1'b0;
         if (!cfg[1]) begin
            rx_state <= ST_IDLE;
         end else begin
            case (rx_state)
               ST_IDLE: begin
                  if (rx_prev && !rx_in) begin
                     rx_state <= ST_START;
                     rx_cnt   <= '0;
                     rx_div   <= div;
                  end
               end
               ST_START: begin
                  if (rx_cnt == (rx_div >> 1) - 16'd1) begin
                     rx_cnt   <= '0;
                     rx_bit   <= '0;
                     rx_state <= rx_in ? ST_IDLE : ST_DATA;
                  end else begin
                     rx_cnt <= rx_cnt + 16'd1;
                  end
               end
               ST_DATA: begin
                  if (rx_cnt == rx_div - 16'd1) begin
                     rx_cnt   <= '0;
                     rx_shift <= {rx_in, rx_shift[DW-1:1]};
                     if (rx_bit == BW'(DW-1)) rx_state <= ST_STOP;
                     else rx_bit <= rx_bit + BW'(1);
                  end else begin
                     rx_cnt <= rx_cnt + 16'd1;
                  end
               end
               ST_STOP: begin
                  if (rx_cnt == rx_div - 16'd1) begin
                     rx_cnt   <= '0;
                     rx_state <= ST_IDLE;
                     rx_push  <= rx_in;
                     rx_ferr  <= !rx_in;
                  end else begin
                     rx_cnt <= rx_cnt + 16'd1;
                  end
               end
               default: rx_state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_v2.sv
// Self-checking bench for uart_v2: register port, TX waveform, loopback, FIFOs, errors, reset.

module tb_uart_v2;
   logic        clk;
   logic        resetn;
   logic [3:0]  reg_we;
   logic [3:0]  reg_re;
   logic [3:0]  reg_addr;
   logic [31:0] reg_di;
   logic [31:0] reg_do;
   logic        ready;
   logic        uart_rx;
   logic        uart_tx;

   int n_checks = 0;
   int n_fail   = 0;
   int mon_div  = 4;
   bit mon_en   = 1'b1;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];

   uart_v2 dut (
      .clk(clk), .resetn(resetn), .reg_we(reg_we), .reg_re(reg_re),
      .reg_addr(reg_addr), .reg_di(reg_di), .reg_do(reg_do), .ready(ready),
      .uart_rx(uart_rx), .uart_tx(uart_tx));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
      cyc(1);
      reg_we = 4'hf; reg_addr = a; reg_di = d;
      cyc(1);
      reg_we = 4'h0;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
      cyc(1);
      reg_re = 4'hf; reg_addr = a;
      cyc(1);
      reg_re = 4'h0;
      check("ready", 32'(ready), 32'd1);
      d = reg_do;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(tag, d, exp);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_v, input int div);
      uart_rx = 1'b0;
      cyc(div);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         cyc(div);
      end
      uart_rx = stop_v;
      cyc(div);
      uart_rx = 1'b1;
      cyc(2);
   endtask

   // TX line monitor: decodes frames mid-bit and scores them against tx_q.
   initial begin : tx_mon
      logic [7:0] b;
      logic       st0, sp;
      forever begin
         @(negedge uart_tx);
         repeat (mon_div / 2) @(negedge clk);
         st0 = uart_tx;
         for (int i = 0; i < 8; i++) begin
            repeat (mon_div) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (mon_div) @(negedge clk);
         sp = uart_tx;
         if (mon_en) begin
            check("tx_start_bit", 32'(st0), 32'd0);
            check("tx_stop_bit", 32'(sp), 32'd1);
            if (tx_q.size() == 0) check("tx_q_nonempty", 32'(tx_q.size()), 32'd1);
            else check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
         end
      end
   end

   initial begin : main
      logic [31:0] d;
      logic [7:0]  v;
      int          lows;
      resetn = 1'b0; reg_we = '0; reg_re = '0; reg_addr = '0; reg_di = '0; uart_rx = 1'b1;
      cyc(3);
      check("rst_uart_tx", 32'(uart_tx), 32'd1);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_reg_do", reg_do, 32'd0);
      resetn = 1'b1;
      cyc(2);
      rd_chk("rst_status", 4'd2, 32'h0000_000A);
      rd_chk("rst_cfg", 4'd0, 32'd0);
      rd_chk("rst_div", 4'd1, 32'd104);

      // Register basics and boundaries
      bus_wr(4'd1, 32'd2);
      rd_chk("div_clamp", 4'd1, 32'd4);
      bus_wr(4'd1, 32'h0001_0004);
      rd_chk("div_4", 4'd1, 32'd4);
      bus_wr(4'd9, 32'hFFFF_FFFF);
      rd_chk("unmapped_rd", 4'd9, 32'd0);
      rd_chk("txdata_rd", 4'd3, 32'd0);
      rd_chk("rxdata_empty", 4'd4, 32'd0);
      rd_chk("status_after_misc", 4'd2, 32'h0000_000A);

      // TX waveform for 0x55 at DIV=4
      bus_wr(4'd0, 32'd1);
      rd_chk("cfg_rd", 4'd0, 32'd1);
      v = 8'h55;
      tx_q.push_back(v);
      bus_wr(4'd3, 32'(v));
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (i < 4) check("tx_wave_start", 32'(uart_tx), 32'd0);
         else if (i < 36) check("tx_wave_data", 32'(uart_tx), 32'(v[(i-4)/4]));
         else check("tx_wave_stop", 32'(uart_tx), 32'd1);
      end
      cyc(1);
      check("tx_wave_idle", 32'(uart_tx), 32'd1);
      rd_chk("tx_done_status", 4'd2, 32'h0000_000A);
      tx_q.push_back(8'hC3);
      bus_wr(4'd3, 32'h0000_00C3);
      rd_chk("tx_busy_status", 4'd2, 32'h0000_001A);
      cyc(50);
      rd_chk("tx_busy_fall", 4'd2, 32'h0000_000A);
      check("tx_q_drained1", 32'(tx_q.size()), 32'd0);

      // Loopback
      bus_wr(4'd0, 32'd7);
      rx_q.push_back(8'hA3);
      bus_wr(4'd3, 32'h0000_00A3);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         cyc(1);
         if (uart_tx !== 1'b1) lows++;
      end
      check("lb_tx_held", 32'(lows), 32'd0);
      rd_chk("lb_status", 4'd2, 32'h0000_0002);
      rd_chk("lb_rxdata", 4'd4, 32'(rx_q.pop_front()));
      rd_chk("lb_status_empty", 4'd2, 32'h0000_000A);
      bus_wr(4'd0, 32'd0);

      // TX FIFO overflow then drain
      for (int i = 0; i < 17; i++) begin
         v = 8'(i * 7 + 1);
         if (i < 16) tx_q.push_back(v);
         bus_wr(4'd3, 32'(v));
      end
      bus_rd(4'd2, d);
      check("ovf_full_bits", d & 32'h0000_00F7, 32'h0000_0081);
      check("ovf_rx_empty", 32'(d[3]), 32'd1);
      bus_wr(4'd0, 32'd1);
      cyc(16 * 40 + 20);
      check("tx_q_drained16", 32'(tx_q.size()), 32'd0);
      rd_chk("ovf_after_drain", 4'd2, 32'h0000_008A);
      bus_wr(4'd2, 32'h0000_0080);
      rd_chk("ovf_w1c", 4'd2, 32'h0000_000A);
      bus_wr(4'd0, 32'd0);

      // RX frame error, glitch, good frame at DIV=8
      bus_wr(4'd1, 32'd8);
      bus_wr(4'd0, 32'd2);
      send_rx(8'h3C, 1'b0, 8);
      rd_chk("ferr_status", 4'd2, 32'h0000_004A);
      bus_wr(4'd2, 32'h0000_0040);
      rd_chk("ferr_w1c", 4'd2, 32'h0000_000A);
      uart_rx = 1'b0;
      cyc(4);
      uart_rx = 1'b1;
      cyc(100);
      rd_chk("glitch_status", 4'd2, 32'h0000_000A);
      rx_q.push_back(8'h3C);
      send_rx(8'h3C, 1'b1, 8);
      rd_chk("rx_good", 4'd4, 32'(rx_q.pop_front()));

      // RX FIFO overrun
      for (int i = 0; i < 17; i++) begin
         v = 8'(i * 13 + 5);
         if (i < 16) rx_q.push_back(v);
         send_rx(v, 1'b1, 8);
      end
      rd_chk("ovr_status", 4'd2, 32'h0000_0026);
      for (int i = 0; i < 16; i++) rd_chk("ovr_rxdata", 4'd4, 32'(rx_q.pop_front()));
      rd_chk("ovr_drained", 4'd2, 32'h0000_002A);
      bus_wr(4'd2, 32'h0000_0020);
      rd_chk("ovr_w1c", 4'd2, 32'h0000_000A);

      // Reset mid-frame
      bus_wr(4'd1, 32'd4);
      bus_wr(4'd0, 32'd1);
      mon_en = 1'b0;
      bus_wr(4'd3, 32'h0000_0000);
      cyc(10);
      check("mid_frame_low", 32'(uart_tx), 32'd0);
      resetn = 1'b0;
      #1;
      check("async_rst_tx", 32'(uart_tx), 32'd1);
      check("async_rst_ready", 32'(ready), 32'd0);
      cyc(3);
      resetn = 1'b1;
      cyc(2);
      rd_chk("post_rst_status", 4'd2, 32'h0000_000A);
      rd_chk("post_rst_cfg", 4'd0, 32'd0);
      rd_chk("post_rst_div", 4'd1, 32'd104);
      cyc(60);
      check("post_rst_tx_idle", 32'(uart_tx), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
